// File: rtl/rv32i_exec_stage.sv
// RV32I execute stage: decodes fields, drives an external ALU, resolves branches/jumps,
// and registers the outcome in a single-entry valid/ready output stage.
module rv32i_exec_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic            funct7b5_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rd_i,
    output logic [9:0]      alu_operation_o,
    output logic [XLEN-1:0] alu_operand1_o,
    output logic [XLEN-1:0] alu_operand2_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_equal_i,
    input  logic            alu_less_i,
    input  logic            alu_less_signed_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic            illegal_o
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [9:0] {
        ALU_NONE = 10'h000,
        ALU_ADD  = 10'h001,
        ALU_SUB  = 10'h002,
        ALU_SLT  = 10'h004,
        ALU_SLTU = 10'h008,
        ALU_AND  = 10'h010,
        ALU_OR   = 10'h020,
        ALU_XOR  = 10'h040,
        ALU_SLL  = 10'h080,
        ALU_SRL  = 10'h100,
        ALU_SRA  = 10'h200
    } alu_op_e;

    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic sub_alt, input logic sra_alt);
        unique case (f3)
            3'b000:  arith_op = sub_alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = sra_alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    alu_op_e         alu_op;
    logic [XLEN-1:0] op1, op2;
    logic [XLEN-1:0] pc_plus_imm, pc_plus_4;
    logic [XLEN-1:0] n_result, n_target;
    logic            n_we, n_taken, n_illegal;
    logic            accept;

    assign pc_plus_imm = pc_i + imm_i;
    assign pc_plus_4   = pc_i + XLEN'(4);

    always_comb begin
        alu_op    = ALU_NONE;
        op1       = rs1_data_i;
        op2       = rs2_data_i;
        n_result  = '0;
        n_target  = '0;
        n_we      = 1'b0;
        n_taken   = 1'b0;
        n_illegal = 1'b0;
        case (opcode_i)
            OPC_OP: begin
                alu_op   = arith_op(funct3_i, funct7b5_i, funct7b5_i);
                n_result = alu_result_i;
                n_we     = 1'b1;
            end
            OPC_OP_IMM: begin
                op2      = imm_i;
                alu_op   = arith_op(funct3_i, 1'b0, funct7b5_i);
                n_result = alu_result_i;
                n_we     = 1'b1;
            end
            OPC_LUI: begin
                op1      = '0;
                op2      = imm_i;
                alu_op   = ALU_ADD;
                n_result = alu_result_i;
                n_we     = 1'b1;
            end
            OPC_AUIPC: begin
                op1      = pc_i;
                op2      = imm_i;
                alu_op   = ALU_ADD;
                n_result = alu_result_i;
                n_we     = 1'b1;
            end
            OPC_JAL: begin
                n_result = pc_plus_4;
                n_target = pc_plus_imm;
                n_taken  = 1'b1;
                n_we     = 1'b1;
            end
            OPC_JALR: begin
                op2      = imm_i;
                alu_op   = ALU_ADD;
                n_result = pc_plus_4;
                n_target = alu_result_i & {{(XLEN-1){1'b1}}, 1'b0};
                n_taken  = 1'b1;
                n_we     = 1'b1;
            end
            OPC_BRANCH: begin
                alu_op   = ALU_SUB;
                n_target = pc_plus_imm;
                case (funct3_i)
                    3'b000:  n_taken = alu_equal_i;
                    3'b001:  n_taken = !alu_equal_i;
                    3'b100:  n_taken = alu_less_signed_i;
                    3'b101:  n_taken = !alu_less_signed_i;
                    3'b110:  n_taken = alu_less_i;
                    3'b111:  n_taken = !alu_less_i;
                    default: n_illegal = 1'b1;
                endcase
            end
            default: n_illegal = 1'b1;
        endcase
        // Illegal encodings squash every side effect, including the ALU request.
        if (n_illegal) begin
            alu_op   = ALU_NONE;
            n_result = '0;
            n_target = '0;
            n_taken  = 1'b0;
            n_we     = 1'b0;
        end
        if (rd_i == 5'd0) begin
            n_we = 1'b0;
        end
    end

    assign alu_operation_o = alu_op;
    assign alu_operand1_o  = op1;
    assign alu_operand2_o  = op2;

    assign ready_o = !flush_i && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o         <= 1'b0;
            result_o        <= '0;
            rd_o            <= '0;
            rd_we_o         <= 1'b0;
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
            illegal_o       <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (accept) begin
            valid_o         <= 1'b1;
            result_o        <= n_result;
            rd_o            <= rd_i;
            rd_we_o         <= n_we;
            branch_taken_o  <= n_taken;
            branch_target_o <= n_target;
            illegal_o       <= n_illegal;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
